// File: rtl/apb_ucpd_pkg.sv
// Shared constants and FSM encoding for the UCPD TXDR feeder.
// Build option: define UCPD_TXFIFO_DEPTH4_EN for a 4-entry TX FIFO (default is a single holding register).
package apb_ucpd_pkg;

`ifdef UCPD_TXFIFO_DEPTH4_EN
   localparam int unsigned FIFO_DEPTH = 4;
`else
   localparam int unsigned FIFO_DEPTH = 1;
`endif

   localparam int unsigned PAYSIZE_W = 10;
   localparam int unsigned LVL_W     = 3;
   localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FEED,
      ST_ACK,
      ST_DRAIN
   } state_t;

   // Pointers wrap at FIFO_DEPTH, which need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

endpackage

// File: rtl/apb_ucpd_txfifo.sv
// Synchronous TX byte FIFO with registered full/empty/level and synchronous flush.
// Depth comes from apb_ucpd_pkg (selected by UCPD_TXFIFO_DEPTH4_EN).
module apb_ucpd_txfifo
   import apb_ucpd_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [7:0]       wdata,
   output logic [7:0]       rdata,
   output logic             full,
   output logic             empty,
   output logic [LVL_W-1:0] lvl
);

   logic [7:0]       mem [2**PTR_W];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;
   logic [LVL_W-1:0] lvl_nxt;

   // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   always_comb begin
      lvl_nxt = lvl;
      case ({do_push, do_pop})
         2'b10:   lvl_nxt = lvl + LVL_W'(1);
         2'b01:   lvl_nxt = lvl - LVL_W'(1);
         default: lvl_nxt = lvl;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         lvl    <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         lvl    <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         lvl   <= lvl_nxt;
         empty <= (lvl_nxt == '0);
         full  <= (lvl_nxt == LVL_W'(FIFO_DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (!flush && do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/apb_ucpd_txdr_feeder.sv
// Feeds APB-written TXDR bytes to the UCPD core on request, tracking payload count and underrun.
// Build option: UCPD_TXFIFO_DEPTH4_EN selects a 4-deep TX FIFO instead of one holding register.
module apb_ucpd_txdr_feeder
   import apb_ucpd_pkg::*;
(
   input  logic                 ic_clk,
   input  logic                 ic_rst_n,
   input  logic                 ucpden,
   input  logic                 tx_start,
   input  logic [PAYSIZE_W-1:0] tx_paysize,
   input  logic                 cpu_we,
   input  logic [7:0]           cpu_wdata,
   input  logic                 txis_req,
   input  logic                 txsend_clr,
   input  logic                 tx_hrst,
   output logic [7:0]           ic_txdr,
   output logic                 txdr_we,
   output logic                 fifo_full,
   output logic                 fifo_empty,
   output logic [LVL_W-1:0]     fifo_lvl,
   output logic                 txund,
   output logic                 tx_done,
   output logic [PAYSIZE_W-1:0] bytes_left
);

   state_t     state;
   logic       flush;
   logic       push;
   logic       pop;
   logic [7:0] fifo_rdata;

   assign flush = tx_hrst || !ucpden;
   assign push  = cpu_we && ucpden;
   // Pop eligibility uses the registered empty flag, so a byte written this cycle cannot fall through.
   assign pop   = (state == ST_FEED) && txis_req && !fifo_empty && !flush;

   apb_ucpd_txfifo u_txfifo (
      .clk   (ic_clk),
      .rst_n (ic_rst_n),
      .flush (flush),
      .push  (push),
      .pop   (pop),
      .wdata (cpu_wdata),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .lvl   (fifo_lvl)
   );

   always_ff @(posedge ic_clk or negedge ic_rst_n) begin
      if (!ic_rst_n) begin
         state      <= ST_IDLE;
         ic_txdr    <= '0;
         txdr_we    <= 1'b0;
         tx_done    <= 1'b0;
         txund      <= 1'b0;
         bytes_left <= '0;
      end else if (flush) begin
         state      <= ST_IDLE;
         txdr_we    <= 1'b0;
         tx_done    <= 1'b0;
         bytes_left <= '0;
         if (!ucpden) txund <= 1'b0;
      end else begin
         txdr_we <= 1'b0;
         tx_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (tx_start) begin
                  bytes_left <= tx_paysize;
                  txund      <= 1'b0;
                  state      <= (tx_paysize == '0) ? ST_DRAIN : ST_FEED;
               end
            end
            ST_FEED: begin
               if (txis_req) begin
                  if (!fifo_empty) begin
                     ic_txdr    <= fifo_rdata;
                     txdr_we    <= 1'b1;
                     bytes_left <= bytes_left - PAYSIZE_W'(1);
                     state      <= ST_ACK;
                  end else begin
                     txund <= 1'b1;
                  end
               end
            end
            ST_ACK: begin
               if (!txis_req) state <= (bytes_left != '0) ? ST_FEED : ST_DRAIN;
            end
            ST_DRAIN: begin
               if (txsend_clr) begin
                  tx_done <= 1'b1;
                  state   <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
